slave_mem_param: RTL and testbench
==================================

// Module: slave_mem_param
// PURPOSE
//  Parametrised, wait-state-capable memory slave on the master-slave bus behind the address router.
//  - Two-phase transfer: setup, then access.
//  - Per-byte write strobes.
//  - Completion signalled on ready.
//  - Out-of-range address flagged on err.
//  Drop-in next generation of the fixed 16-bit/16K slave.
// PARAMETERS
//  DATA_W       16     data width in bits; must be a multiple of 8
//  ADDR_W       16     address width in bits; word-addressed
//  DEPTH        16384  number of words; addr >= DEPTH is out of range
//  WAIT_CYCLES  0      extra access cycles inserted before ready (0..255)
// PORTS
//  clk     in   1         clock, rising edge
//  rst_n   in   1         reset, asynchronous, active-low
//  sel     in   1         slave selected by router
//  enable  in   1         0 = setup phase, 1 = access phase
//  wr_dir  in   1         0 = read, 1 = write
//  addr    in   ADDR_W    word address
//  wdata   in   DATA_W    write data
//  wstrb   in   DATA_W/8  byte-lane write enables; ignored on reads
//  rdata   out  DATA_W    read data; valid while ready=1 on a read
//  ready   out  1         transfer completes in this cycle
//  err     out  1         error response; only meaningful while ready=1
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, wait cnt=0, ready=0, err=0, rdata=0.
//   Memory array is not cleared. Any in-flight write is dropped.
//  FSM states:
//   - IDLE: on sel=1 & enable=0 (setup), capture addr/wr_dir/wdata/wstrb, load cnt=WAIT_CYCLES, go ACCESS.
//     On a read setup: rdata <= mem[addr] (in range) or 0 (out of range).
//     err_q <= out_of_range.
//     enable=1 without a preceding setup is ignored: stays IDLE, no ready.
//   - ACCESS: ready = (cnt==0); err = err_q & ready (both decoded from registered state).
//     While cnt!=0 and sel=1: cnt decrements each cycle.
//     When sel=1 & enable=1 & ready:
//      - write in range: for each lane i with wstrb[i]=1, mem[a][8i+7:8i] <= wdata_q lane i.
//      - then next state=IDLE.
//     sel=0 in ACCESS (abort): go IDLE; no write; rdata holds.
//  Latency: ready is high in access cycle WAIT_CYCLES+1, i.e. clock WAIT_CYCLES+2 counted from setup.
//  Back-to-back: a setup may follow in the cycle after ready; no dead cycle required.
//  Write data and strobes are taken from the setup-phase capture; changes during access are ignored.
//  wstrb=0 write: completes normally with ready, memory unchanged.
//  Out-of-range:
//   - write: no memory change, err=1 with ready.
//   - read: rdata=0, err=1 with ready.
//  Address bits above clog2(DEPTH) participate in the range check; no aliasing.
//  rdata holds its last value between transfers and after writes.
// CONFIGURATION
//  SLAVE_PARITY_EN defined:
//   - Each word stores one even-parity bit per byte lane, updated only for strobed lanes on write.
//   - On read setup, parity is recomputed; any lane mismatch sets err_q.
//   - The read completes with ready, err=1 and rdata = the stored (possibly corrupt) data.
//  SLAVE_PARITY_EN undefined:
//   - No parity storage or checking.
//   - err is raised for out-of-range addresses only.
// TESTING
//  1 rst_n=0 mid-stream, any inputs -> ready=0, err=0, rdata=0 immediately (no clock needed).
//  2 WAIT=0: write 0xA5A5 @0x0010 wstrb=2'b11, then read @0x0010 -> ready in 2nd cycle of each transfer; rdata=0xA5A5, err=0.
//  3 write 0x1234 @0x0020, write 0xFF00 wstrb=2'b10 @0x0020, read @0x0020 -> rdata=0xFF34.
//  4 WAIT_CYCLES=2: read @0x0010 -> ready=0 for 2 access cycles, ready=1 on 3rd with rdata=0xA5A5.
//    Also check a back-to-back setup on the following cycle is accepted.
//  5 DEPTH=16384: write 0xBEEF @0x4000 -> err=1 with ready; read @0x4000 -> rdata=0, err=1; mem[0x0000] unchanged.
//  6 WAIT=2 write 0x5555 @0x0030, sel=0 during wait -> mem[0x0030] unchanged.
//    rst_n low during wait -> ready=0, state IDLE.
//    With SLAVE_PARITY_EN: backdoor flip bit 0 of mem[0x0010], read @0x0010 -> err=1, rdata=0xA5A4.

Source files
------------

// File: rtl/slave_mem_param_if.sv
// Bus interface between the address router (master) and a memory slave.
// Carries the setup/access handshake, write strobes and the ready/err response.
interface slave_mem_param_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic                  sel;
    logic                  enable;
    logic                  wr_dir;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;
    logic                  err;

    modport master (
        output sel, enable, wr_dir, addr, wdata, wstrb,
        input  rdata, ready, err
    );

    modport slave (
        input  sel, enable, wr_dir, addr, wdata, wstrb,
        output rdata, ready, err
    );
endinterface

// File: rtl/slave_mem_param.sv
// Parametrised memory slave with a two-phase (setup, access) transfer,
// per-byte write strobes, optional wait states and an out-of-range error.
// Optional feature: define SLAVE_PARITY_EN to store one even-parity bit per
// byte lane and flag parity mismatches on reads via err.
module slave_mem_param #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH       = 16384,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic              clk,
    input logic              rst_n,
    slave_mem_param_if.slave bus
);
    localparam int unsigned     LANES   = DATA_W / 8;
    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q;
    logic               wr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [LANES-1:0]   wstrb_q;
    logic               err_q;
    logic [DATA_W-1:0]  rdata_q;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               setup;
    logic               capture;
    logic               ready;
    logic               mem_we;
    logic               oor;
    logic               setup_err;
    logic [IDX_W-1:0]   rd_idx;
    logic [DATA_W-1:0]  rd_word;

    // Full address width takes part in the range check, so no aliasing.
    assign oor     = ({1'b0, bus.addr} >= DEPTH_L);
    assign rd_idx  = bus.addr[IDX_W-1:0];
    assign rd_word = mem[rd_idx];
    assign setup   = bus.sel & ~bus.enable;
    assign capture = (state_q == StIdle) & setup;
    assign ready   = (state_q == StAccess) && (cnt_q == '0);
    // On a write, err_q only ever holds the out-of-range flag.
    assign mem_we  = ready & bus.sel & bus.enable & wr_q & ~err_q;

    assign bus.ready = ready;
    assign bus.err   = err_q & ready;
    assign bus.rdata = rdata_q;

`ifdef SLAVE_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] rd_par;
    logic [LANES-1:0] par_fail;

    assign rd_par = par_mem[rd_idx];

    // Recompute even parity per lane of the word being read.
    always_comb begin
        par_fail = '0;
        for (int i = 0; i < LANES; i++) begin
            par_fail[i] = (^rd_word[8*i +: 8]) ^ rd_par[i];
        end
    end

    assign setup_err = oor | (~bus.wr_dir & (|par_fail));

    // Parity bits follow the strobed lanes of each completed write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wstrb_q[i]) par_mem[idx_q][i] <= ^wdata_q[8*i +: 8];
            end
        end
    end
`else
    assign setup_err = oor;
`endif

    // Next-state logic: wait-state countdown, completion and abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (setup) begin
                    state_d = StAccess;
                    cnt_d   = 8'(WAIT_CYCLES);
                end
            end
            StAccess: begin
                if (!bus.sel) begin
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (bus.enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, setup-phase capture and read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q   <= rd_idx;
                wr_q    <= bus.wr_dir;
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
                err_q   <= setup_err;
                if (!bus.wr_dir) rdata_q <= oor ? '0 : rd_word;
            end
        end
    end

    // Byte-lane writes; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wstrb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_slave_mem_param.sv
// Scoreboard bench for slave_mem_param: two instances (0 and 2 wait states),
// directed transfers followed by randomized traffic against a word-level model.
module tb_slave_mem_param;
    localparam int unsigned DEPTH = 16384;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slave_mem_param_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
    slave_mem_param_if #(.DATA_W(16), .ADDR_W(16)) bus2 ();

    slave_mem_param #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    slave_mem_param #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    int          errors = 0;
    int          checks = 0;
    exp_t        q0[$];
    exp_t        q2[$];
    logic [15:0] model_mem [int];
    bit          par_bad [int];
    logic [15:0] last_rd [2];
    int          waits [2] = '{0, 2};
    logic [15:0] aset [6] = '{16'h0000, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h3FFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int d, input logic s, input logic e, input logic w,
                         input logic [15:0] a, input logic [15:0] wd, input logic [1:0] st);
        if (d == 0) begin
            bus0.sel = s; bus0.enable = e; bus0.wr_dir = w;
            bus0.addr = a; bus0.wdata = wd; bus0.wstrb = st;
        end else begin
            bus2.sel = s; bus2.enable = e; bus2.wr_dir = w;
            bus2.addr = a; bus2.wdata = wd; bus2.wstrb = st;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? bus0.ready : bus2.ready;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        drive(d, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        repeat (n) tick();
    endtask

    // Work out the expected response from the model, push it, then run the transfer.
    task automatic xfer(input int d, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] st);
        exp_t        e;
        int          key;
        bit          oor;
        int          n;
        logic [15:0] w;
        key = d * 65536 + int'(a);
        oor = (int'(a) >= DEPTH);
        if (wr) begin
            if (!oor) begin
                w = model_mem.exists(key) ? model_mem[key] : 16'h0;
                if (st[0]) begin
                    w[7:0] = wd[7:0];
                    par_bad[key] = 1'b0;
                end
                if (st[1]) w[15:8] = wd[15:8];
                model_mem[key] = w;
            end
            e.rdata = last_rd[d];
            e.err   = oor;
        end else begin
            e.rdata = oor ? 16'h0 : model_mem[key];
            e.err   = oor | (par_bad.exists(key) && par_bad[key]);
            last_rd[d] = e.rdata;
        end
        if (d == 0) q0.push_back(e); else q2.push_back(e);

        drive(d, 1'b1, 1'b0, wr, a, wd, st);
        tick();
        // Data and strobes changed during access must be ignored.
        drive(d, 1'b1, 1'b1, wr, a, ~wd, ~st);
        n = 1;
        while (rdy(d) !== 1'b1 && n <= 10) begin
            tick();
            n++;
        end
        check($sformatf("latency dut%0d", d), 32'(n), 32'(waits[d] + 1));
        tick();
    endtask

    task automatic mon(input int d, input logic r, input logic [15:0] rd, input logic er);
        exp_t e;
        if (r === 1'b1) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q2.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready dut%0d: ready=1 with no transfer pending", d);
            end else begin
                if (d == 0) e = q0.pop_front(); else e = q2.pop_front();
                check($sformatf("rdata dut%0d", d), 32'(rd), 32'(e.rdata));
                check($sformatf("err dut%0d", d), 32'(er), 32'(e.err));
            end
        end
    endtask

    // Monitor: compares each completed transfer against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, bus0.ready, bus0.rdata, bus0.err);
            mon(1, bus2.ready, bus2.rdata, bus2.err);
        end
    end

    initial begin
        int d;
        logic [15:0] a;
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        idle(0, 0);
        idle(1, 0);
        repeat (2) tick();
        check("reset ready0", 32'(bus0.ready), 0);
        check("reset err0", 32'(bus0.err), 0);
        check("reset rdata0", 32'(bus0.rdata), 0);
        check("reset rdata2", 32'(bus2.rdata), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Known contents for every address read later.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) xfer(k, 1'b1, aset[i], 16'($urandom), 2'b11);
        end

        // Enable without setup is ignored.
        drive(0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);
        repeat (3) begin
            tick();
            check("no_setup ready", 32'(bus0.ready), 0);
        end
        idle(0, 1);

        xfer(0, 1'b1, 16'h0010, 16'hA5A5, 2'b11);
        xfer(0, 1'b0, 16'h0010, 16'h0000, 2'b00);
        xfer(0, 1'b1, 16'h0020, 16'h1234, 2'b11);
        xfer(0, 1'b1, 16'h0020, 16'hFF00, 2'b10);
        xfer(0, 1'b0, 16'h0020, 16'h0000, 2'b00);
        xfer(0, 1'b1, 16'h0030, 16'h9999, 2'b00);
        xfer(0, 1'b0, 16'h0030, 16'h0000, 2'b00);
        idle(0, 1);

        xfer(1, 1'b1, 16'h0010, 16'hA5A5, 2'b11);
        idle(1, 1);
        xfer(1, 1'b0, 16'h0010, 16'h0000, 2'b00);
        xfer(1, 1'b0, 16'h0010, 16'h0000, 2'b00);
        idle(1, 1);

        xfer(0, 1'b1, 16'h4000, 16'hBEEF, 2'b11);
        xfer(0, 1'b0, 16'h4000, 16'h0000, 2'b00);
        xfer(0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        xfer(0, 1'b0, 16'hFFFF, 16'h0000, 2'b00);
        idle(0, 1);

        // Abort a wait-state write by dropping sel.
        drive(1, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h5555, 2'b11);
        tick();
        drive(1, 1'b1, 1'b1, 1'b1, 16'h0030, 16'h5555, 2'b11);
        tick();
        drive(1, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h5555, 2'b11);
        tick();
        check("abort ready", 32'(bus2.ready), 0);
        xfer(1, 1'b0, 16'h0030, 16'h0000, 2'b00);

        // Reset in the middle of a wait-state write.
        drive(1, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h5555, 2'b11);
        tick();
        drive(1, 1'b1, 1'b1, 1'b1, 16'h0030, 16'h5555, 2'b11);
        rst_n = 1'b0;
        #1;
        check("async_rst ready2", 32'(bus2.ready), 0);
        check("async_rst err2", 32'(bus2.err), 0);
        check("async_rst rdata2", 32'(bus2.rdata), 0);
        check("async_rst rdata0", 32'(bus0.rdata), 0);
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post_rst ready2", 32'(bus2.ready), 0);
        idle(1, 1);
        xfer(1, 1'b0, 16'h0030, 16'h0000, 2'b00);

`ifdef SLAVE_PARITY_EN
        // Corrupt one stored bit behind the parity's back.
        xfer(0, 1'b1, 16'h0010, 16'hA5A5, 2'b11);
        u_dut0.mem[16'h0010][0] = ~u_dut0.mem[16'h0010][0];
        model_mem[16'h0010] = model_mem[16'h0010] ^ 16'h0001;
        par_bad[16'h0010] = 1'b1;
        xfer(0, 1'b0, 16'h0010, 16'h0000, 2'b00);
`endif

        for (int i = 0; i < 120; i++) begin
            d = i % 2;
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(DEPTH, 16'hFFFF));
            else a = aset[$urandom_range(0, 5)];
            xfer(d, 1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom));
            if ($urandom_range(0, 1) == 1) idle(d, $urandom_range(0, 2));
        end
        idle(0, 0);
        idle(1, 0);
        repeat (4) tick();
        check("scoreboard drained", 32'(q0.size() + q2.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
